tdm_demux: RTL and testbench
============================

TDM_DEMUX -- requirements
Module: tdm_demux

Interface
REQ-001 SHALL have parameter NCH, default 4, number of time slots (channels) per frame, range 2..8.
REQ-002 SHALL have parameter W, default 8, bits per channel word, range 2..16.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port din  input  1  serial TDM bit stream, MSB of each word first.
REQ-006 SHALL have port din_valid  input  1  din qualifier; the stream advances only on cycles where din_valid=1.
REQ-007 SHALL have port sync  input  1  frame marker, coincident with bit 0 of channel 0; ignored when din_valid=0.
REQ-008 SHALL have port ch_data  output  NCH*W  held channel words, channel k at bits [k*W+W-1 : k*W].
REQ-009 SHALL have port ch_valid  output  NCH  one-cycle strobe per channel when its word updates.
REQ-010 SHALL have port frame_done  output  1  one-cycle strobe when channel NCH-1 completes.
REQ-011 SHALL have port locked  output  1  high while in state LOCKED.
REQ-012 SHALL have port sync_err  output  1  one-cycle strobe on misaligned sync.

Function
REQ-013 SHALL implement FSM states HUNT and LOCKED; HUNT discards all bits.
REQ-014 SHALL go HUNT->LOCKED on a valid bit with sync=1; that bit is bit 0 (MSB) of channel 0.
REQ-015 SHALL keep bit counter (0..W-1) and slot counter (0..NCH-1), advancing only on valid bits in LOCKED.
REQ-016 SHALL shift valid bits into a W-bit shift register, MSB first.
REQ-017 SHALL, on the valid bit with bit counter = W-1, write the completed word into slot k of ch_data and pulse ch_valid[k] on the following cycle (latency 1 clk from last bit sample).
REQ-018 SHALL pulse frame_done in the same cycle as ch_valid[NCH-1].
REQ-019 SHALL wrap the slot counter NCH-1->0 and the bit counter W-1->0 without gaps.
REQ-020 SHALL accept sync at expected frame start (slot 0, bit 0) silently, with no error.
REQ-021 SHALL, on sync at any other position in LOCKED, pulse sync_err, discard the partial word, and take that bit as bit 0 of channel 0 (realign); completed words already in ch_data are kept.
REQ-022 SHALL freeze counters, shift register and FSM state on din_valid=0 gaps of any length.
REQ-023 SHALL hold ch_data words until overwritten; ch_valid, frame_done and sync_err are never asserted for more than one cycle per event.

Reset
REQ-024 SHALL, on rst_n=0, immediately set state HUNT, counters 0, shift register 0, ch_data 0, ch_valid 0, frame_done 0, locked 0, sync_err 0.
REQ-025 SHALL, on reset mid-frame, discard the partial frame and require a new sync to relock.

Structure
REQ-026 SHALL place the FSM state encoding (HUNT, LOCKED) and default NCH/W constants in shared package tdm_pkg, which the companion TDM multiplexer also uses.
REQ-027 SHALL implement the shift register plus bit counter as sub-module tdm_deser (W-bit serial-to-parallel, word_done strobe); the slot/FSM/output logic remains in tdm_demux.

Verification
REQ-028 SHALL cover: reset, then sync with one frame 0xA5,0x3C,0xFF,0x01 continuous -> ch_valid[0..3] on successive word ends, ch_data=0x01FF3CA5, frame_done once, locked=1.
REQ-029 SHALL cover: bits before first sync -> no ch_valid, locked=0, ch_data=0.
REQ-030 SHALL cover: same frame with din_valid=0 gaps of 1 and 5 cycles inserted -> identical ch_data and strobe order.
REQ-031 SHALL cover: sync at slot 1 bit 3 -> sync_err pulse one cycle, following 32 bits decode as a full frame from channel 0, earlier ch0 word retained.
REQ-032 SHALL cover: rst_n pulled low at slot 2 bit 4 -> all outputs 0 asynchronously, locked=0 until next sync.
REQ-033 SHALL cover: back-to-back frames with sync at each frame start -> no sync_err, frame_done every 32 valid bits.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared TDM definitions: FSM states and default frame geometry.
// Used by both the TDM multiplexer and demultiplexer.
package tdm_pkg;

  localparam int TDM_NCH = 4;
  localparam int TDM_W   = 8;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } tdm_state_t;

endpackage

// File: rtl/tdm_demux_if.sv
// Serial TDM input and demultiplexed channel outputs.
// Master drives the stream; slave is the demux.
interface tdm_demux_if
  import tdm_pkg::*;
#(
  parameter int NCH = TDM_NCH,
  parameter int W   = TDM_W
);

  logic             din;
  logic             din_valid;
  logic             sync;
  logic [NCH*W-1:0] ch_data;
  logic [NCH-1:0]   ch_valid;
  logic             frame_done;
  logic             locked;
  logic             sync_err;

  modport master (
    output din, din_valid, sync,
    input  ch_data, ch_valid,
    input  frame_done, locked, sync_err
  );

  modport slave (
    input  din, din_valid, sync,
    output ch_data, ch_valid,
    output frame_done, locked, sync_err
  );

endinterface

// File: rtl/tdm_deser.sv
// W-bit serial-to-parallel converter, MSB first.
// start restarts a word with the current bit as its MSB.
module tdm_deser
  import tdm_pkg::*;
#(
  parameter int W = TDM_W,
  localparam int BW = $clog2(W)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          start,
  input  logic          bit_in,
  output logic [BW-1:0] bit_cnt,
  output logic [W-1:0]  word,
  output logic          word_done
);

  logic [W-2:0] sr;

  // Completed word includes the bit being sampled this cycle
  assign word      = {sr, bit_in};
  assign word_done = en && !start &&
                     (bit_cnt == BW'(W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (en) begin
      if (start) begin
        sr      <= (W-1)'(bit_in);
        bit_cnt <= BW'(1);
      end else begin
        sr      <= word[W-2:0];
        bit_cnt <= word_done ? '0
                             : bit_cnt + BW'(1);
      end
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// TDM demultiplexer: locks on sync, splits the serial
// stream into NCH held words with per-channel strobes.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int NCH = TDM_NCH,
  parameter int W   = TDM_W
) (
  input  logic       clk,
  input  logic       rst_n,
  tdm_demux_if.slave bus
);

  localparam int SW = $clog2(NCH);
  localparam int BW = $clog2(W);

  tdm_state_t    state;
  tdm_state_t    state_nxt;
  logic [SW-1:0] slot;
  logic [BW-1:0] bit_cnt;
  logic [W-1:0]  word;
  logic          word_done;
  logic          start;
  logic          en;
  logic          aligned;

  assign start   = bus.din_valid && bus.sync;
  assign en      = bus.din_valid &&
                   (state == LOCKED || bus.sync);
  assign aligned = (slot == '0) && (bit_cnt == '0);

  tdm_deser #(.W(W)) u_deser (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .start     (start),
    .bit_in    (bus.din),
    .bit_cnt   (bit_cnt),
    .word      (word),
    .word_done (word_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HUNT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start) state_nxt = LOCKED;
  end

  assign bus.locked = (state == LOCKED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot           <= '0;
      bus.ch_data    <= '0;
      bus.ch_valid   <= '0;
      bus.frame_done <= 1'b0;
      bus.sync_err   <= 1'b0;
    end else begin
      bus.ch_valid   <= '0;
      bus.frame_done <= 1'b0;
      bus.sync_err   <= 1'b0;
      if (start) begin
        // Sync realigns; only an off-boundary one is an error
        slot <= '0;
        if (state == LOCKED && !aligned)
          bus.sync_err <= 1'b1;
      end else if (word_done) begin
        for (int k = 0; k < NCH; k++)
          if (slot == SW'(k))
            bus.ch_data[k*W +: W] <= word;
        bus.ch_valid[slot] <= 1'b1;
        bus.frame_done <= (slot == SW'(NCH - 1));
        slot <= (slot == SW'(NCH - 1)) ? '0
                                       : slot + SW'(1);
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux.sv
// Directed bench for tdm_demux (NCH=4, W=8).
module tb_tdm_demux;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  tdm_demux_if #(.NCH(4), .W(8)) bus ();

  tdm_demux #(.NCH(4), .W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    string       name;
    logic [31:0] words;
    int          ga;
    int          gal;
    int          gb;
    int          gbl;
  } vec_t;

  vec_t vecs[4];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int se_cnt = 0;
  int q_ch[$];
  int fd_cyc[$];

  always @(posedge clk) begin
    #1;
    cyc++;
    for (int k = 0; k < 4; k++)
      if (bus.ch_valid[k]) q_ch.push_back(k);
    if (bus.sync_err) se_cnt++;
    if (bus.frame_done) begin
      fd_cyc.push_back(cyc);
      checks++;
      if (bus.ch_valid[3] !== 1'b1) begin
        failures++;
        $display("FAIL fd_with_cv3 actual=%b required=1",
                 bus.ch_valid[3]);
      end
    end
  end

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endtask

  task automatic send_bit(logic b, logic s, logic v);
    bus.din = b;
    bus.sync = s;
    bus.din_valid = v;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) send_bit(1'b1, 1'b1, 1'b0);
  endtask

  function automatic logic frame_bit(logic [31:0] w, int i);
    return w[(i / 8) * 8 + 7 - (i % 8)];
  endfunction

  task automatic send_range(logic [31:0] w, int lo, int hi,
                            logic s);
    for (int i = lo; i < hi; i++)
      send_bit(frame_bit(w, i), s && (i == lo), 1'b1);
  endtask

  task automatic send_frame(logic [31:0] w, int ga, int gal,
                            int gb, int gbl);
    for (int i = 0; i < 32; i++) begin
      if (i == ga) idle(gal);
      if (i == gb) idle(gbl);
      send_bit(frame_bit(w, i), i == 0, 1'b1);
    end
  endtask

  function automatic int order();
    int o = 0;
    foreach (q_ch[i]) o = o * 16 + q_ch[i] + 1;
    return o;
  endfunction

  initial begin
    int fd0;
    int se0;
    vecs[0] = '{"basic", 32'h01FF3CA5, -1, 0, -1, 0};
    vecs[1] = '{"gaps", 32'h01FF3CA5, 5, 1, 20, 5};
    vecs[2] = '{"gap_wend", 32'h12345678, 8, 5, 31, 1};
    vecs[3] = '{"edge_bits", 32'h80000001, 7, 1, 24, 5};

    bus.din = 1'b0;
    bus.sync = 1'b0;
    bus.din_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ch_data", bus.ch_data, 0);
    chk("rst_ch_valid", bus.ch_valid, 0);
    chk("rst_locked", bus.locked, 0);
    chk("rst_frame_done", bus.frame_done, 0);
    chk("rst_sync_err", bus.sync_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    q_ch.delete();
    send_range(32'h5A5A5A5A, 0, 24, 1'b0);
    idle(1);
    chk("hunt_locked", bus.locked, 0);
    chk("hunt_ch_data", bus.ch_data, 0);
    chk("hunt_strobes", q_ch.size(), 0);

    for (int v = 0; v < 4; v++) begin
      q_ch.delete();
      fd0 = fd_cyc.size();
      se0 = se_cnt;
      send_frame(vecs[v].words, vecs[v].ga, vecs[v].gal,
                 vecs[v].gb, vecs[v].gbl);
      idle(1);
      chk({vecs[v].name, "_data"}, bus.ch_data,
          vecs[v].words);
      chk({vecs[v].name, "_order"}, order(), 'h1234);
      chk({vecs[v].name, "_fd"}, fd_cyc.size() - fd0, 1);
      chk({vecs[v].name, "_serr"}, se_cnt - se0, 0);
      chk({vecs[v].name, "_locked"}, bus.locked, 1);
    end

    q_ch.delete();
    fd0 = fd_cyc.size();
    se0 = se_cnt;
    send_frame(32'hAABBCCDD, -1, 0, -1, 0);
    send_frame(32'h11223344, -1, 0, -1, 0);
    send_frame(32'h55667788, -1, 0, -1, 0);
    idle(1);
    chk("b2b_fd", fd_cyc.size() - fd0, 3);
    chk("b2b_serr", se_cnt - se0, 0);
    chk("b2b_gap1", fd_cyc[fd0 + 1] - fd_cyc[fd0], 32);
    chk("b2b_gap2", fd_cyc[fd0 + 2] - fd_cyc[fd0 + 1], 32);
    chk("b2b_data", bus.ch_data, 32'h55667788);

    send_range(32'h0000E011, 0, 11, 1'b1);
    chk("ra_pre", bus.ch_data, 32'h55667711);
    q_ch.delete();
    se0 = se_cnt;
    send_range(32'hEFBEADDE, 0, 1, 1'b1);
    chk("ra_err", bus.sync_err, 1);
    chk("ra_keep", bus.ch_data, 32'h55667711);
    send_range(32'hEFBEADDE, 1, 32, 1'b0);
    idle(1);
    chk("ra_err_once", se_cnt - se0, 1);
    chk("ra_data", bus.ch_data, 32'hEFBEADDE);
    chk("ra_order", order(), 'h1234);

    send_range(32'h0F0E0D0C, 0, 20, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_ch_data", bus.ch_data, 0);
    chk("arst_locked", bus.locked, 0);
    chk("arst_ch_valid", bus.ch_valid, 0);
    chk("arst_fd", bus.frame_done, 0);
    chk("arst_serr", bus.sync_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    q_ch.delete();
    send_range(32'h0F0E0D0C, 20, 32, 1'b0);
    send_range(32'h0F0E0D0C, 0, 16, 1'b0);
    idle(1);
    chk("post_rst_locked", bus.locked, 0);
    chk("post_rst_strobes", q_ch.size(), 0);
    chk("post_rst_data", bus.ch_data, 0);
    send_frame(32'hCAFEBABE, -1, 0, -1, 0);
    idle(1);
    chk("relock_locked", bus.locked, 1);
    chk("relock_data", bus.ch_data, 32'hCAFEBABE);
    chk("relock_order", order(), 'h1234);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
